debug_word_serializer: RTL and testbench
========================================

Name: debug_word_serializer

Overview:
- Sits between the debug unit and the UART transmitter on the TX path.
- Accepts NB-bit words (PC, register, memory, ALU values) from the debug unit through a valid/ready handshake and buffers them in a small FIFO.
- Splits each word into NB/DATA_BITS bytes, least-significant byte first.
- Feeds one byte at a time to the transmitter using its start-pulse / done-pulse handshake, so the debug unit never waits per byte.

Parameters:
- NB, 32, word width; must be a multiple of DATA_BITS.
- DATA_BITS, 8, UART byte width.
- FIFO_DEPTH, 4, number of words buffered; must be a power of 2 and at least 2.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_word_valid  in  1  debug unit presents a word.
- i_word_data  in  NB  word to send.
- o_word_ready  out  1  FIFO not full; a word is accepted on an edge where i_word_valid and o_word_ready are both 1.
- i_uart_tx_done  in  1  one-cycle pulse from the transmitter when the current byte is fully sent.
- o_uart_tx_start  out  1  one-cycle pulse that starts transmission of o_uart_tx_data.
- o_uart_tx_data  out  DATA_BITS  byte to transmit; stable from the start pulse until done.
- o_busy  out  1  1 whenever the FSM is not IDLE or the FIFO is non-empty.
- o_fifo_count  out  clog2(FIFO_DEPTH)+1  words currently queued, not counting the word being serialized.
- o_overflow  out  1  sticky; set when i_word_valid=1 while o_word_ready=0.

Behaviour:
- Reset (i_reset=0 at an edge) clears everything:
  - FSM goes to IDLE; FIFO pointers and count go to 0.
  - o_uart_tx_start=0, o_uart_tx_data=0, o_overflow=0, o_busy=0, o_fifo_count=0.
  - o_word_ready=1 in the cycle after reset releases.
- Reset mid-transfer abandons the in-flight word and all queued words. No further start pulse is issued. The transmitter shares the reset.
- FIFO:
  - Circular buffer with write/read pointers that wrap modulo FIFO_DEPTH.
  - o_word_ready = (count != FIFO_DEPTH), combinational from the registered count.
  - When the FIFO is full, o_word_ready=0 even if a pop occurs in the same cycle.
  - A push and a pop on the same edge leave the count unchanged and both take effect.
  - Words are never reordered or duplicated.
  - A push while ready=0 is dropped, the FIFO is unchanged, and o_overflow is set until reset.
- FSM states:
  - IDLE: if count>0, go to LOAD; otherwise stay.
  - LOAD: pop the FIFO head into the NB-bit shift register, set byte_idx=0, go to START.
  - START: o_uart_tx_start=1 for exactly this cycle; o_uart_tx_data=shift[DATA_BITS-1:0]; go to WAIT.
  - WAIT: o_uart_tx_data held stable. On i_uart_tx_done=1:
    - if byte_idx == NB/DATA_BITS-1, go to IDLE;
    - otherwise shift right by DATA_BITS, increment byte_idx, go to START.
- i_uart_tx_done is ignored in IDLE, LOAD and START.
- A done pulse and a new push on the same edge are both honoured.
- Latency:
  - A word accepted on edge k into an empty FIFO with the FSM in IDLE gives o_uart_tx_start=1 in the cycle between edges k+2 and k+3.
  - A done pulse at edge d gives the next byte's start pulse in the cycle between edges d+1 and d+2.
  - After the last byte's done, IDLE costs one cycle, so the next word's first start pulse comes 3 cycles after that done.
- Exactly NB/DATA_BITS start pulses are issued per word; with the defaults that is 4.
- o_busy drops to 0 only when the FSM is in IDLE with count=0.

Test Plan:
- Reset then push 0xDEADBEEF (transmitter model returns done 10 cycles after each start) -> bytes EF, BE, AD, DE in order; 4 start pulses, each 1 cycle wide; first start 2 cycles after the accept edge; o_busy=0 afterwards.
- Hold i_uart_tx_done=0 and push 0x1,0x2,... every cycle -> exactly FIFO_DEPTH+1 (=5) words accepted, then o_word_ready=0 and o_fifo_count=4. Next push sets o_overflow=1. Releasing done gives bytes of words 1..5 in order; word 6 never appears.
- Push one word on the same edge as a done pulse while full -> count unchanged, both actions take effect, ordering preserved.
- Spurious i_uart_tx_done pulses in IDLE and in START -> no state change and no extra bytes.
- Assert i_reset=0 mid-word (after byte 2) with 3 words queued -> next cycle: count=0, o_busy=0, o_overflow=0, no further start pulses. A new word 0x00000080 then transmits 80, 00, 00, 00.
- Random valid/done timing over 200 words against a reference queue -> byte stream matches, o_uart_tx_data never changes while in WAIT.

Source files
------------

// File: rtl/debug_word_serializer.sv
// -----------------------------------------------------------------------------
// debug_word_serializer
//
// Sits between the debug unit and the UART transmitter on the TX path. Words
// from the debug unit are queued in a small circular FIFO. Each word is then
// split into NB/DATA_BITS bytes and sent least-significant byte first. The
// debug unit only waits when the FIFO is full, never once per byte.
//
// Handshakes:
//   word side  : a word is taken on a rising edge where i_word_valid and
//                o_word_ready are both 1. o_word_ready depends only on the
//                registered FIFO count, so a pop in the same cycle does not
//                make a full FIFO ready. When i_word_valid is high while
//                o_word_ready is low, the word is dropped and o_overflow
//                stays set until reset.
//   uart side  : o_uart_tx_start is a one-cycle pulse. o_uart_tx_data stays
//                stable from that pulse until i_uart_tx_done, a one-cycle
//                pulse from the transmitter, is sampled in WAIT.
//
// Ports:
//   i_clk, i_reset     clock; synchronous active-low reset
//   i_word_valid       debug unit presents i_word_data
//   i_word_data        NB-bit word to send
//   o_word_ready       FIFO is not full
//   i_uart_tx_done     transmitter finished the current byte
//   o_uart_tx_start    start transmitting o_uart_tx_data
//   o_uart_tx_data     byte being transmitted
//   o_busy             FSM not IDLE, or words still queued
//   o_fifo_count       queued words, excluding the word being serialized
//   o_overflow         sticky: a word was offered while the FIFO was full
//   o_dbg_state        current FSM state (0 IDLE, 1 LOAD, 2 START, 3 WAIT)
// -----------------------------------------------------------------------------
module debug_word_serializer #(
    parameter int NB         = 32,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_word_valid,
    input  logic [NB-1:0]                 i_word_data,
    output logic                          o_word_ready,
    input  logic                          i_uart_tx_done,
    output logic                          o_uart_tx_start,
    output logic [DATA_BITS-1:0]          o_uart_tx_data,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_overflow,
    output logic [1:0]                    o_dbg_state
);

    localparam int NBYTES = NB / DATA_BITS;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t               state, state_next;

    logic [NB-1:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;

    logic [NB-1:0]        shift_reg;
    logic [IDX_W-1:0]     byte_idx;
    logic                 overflow;

    logic                 push, pop, last_byte, byte_done;

    assign o_word_ready = (count != CNT_W'(FIFO_DEPTH));
    assign push         = i_word_valid && o_word_ready;
    // The FSM visits LOAD only when the FIFO holds at least one word, and only
    // LOAD pops, so a pop can never hit an empty FIFO.
    assign pop          = (state == S_LOAD);
    assign last_byte    = (byte_idx == IDX_W'(NBYTES - 1));
    assign byte_done    = (state == S_WAIT) && i_uart_tx_done;

    // FIFO storage. It needs no reset because the pointers decide what is valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_word_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (i_word_valid && !o_word_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic. i_uart_tx_done only matters in WAIT.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (count != '0) state_next = S_LOAD;
            S_LOAD:  state_next = S_START;
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (i_uart_tx_done) begin
                    state_next = last_byte ? S_IDLE : S_START;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Byte shifter. The low byte of shift_reg is the byte on the UART bus.
    // It changes only in LOAD or when a done pulse arrives, so it is stable
    // for the whole time from START through WAIT.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            shift_reg <= '0;
            byte_idx  <= '0;
        end else if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            byte_idx  <= '0;
        end else if (byte_done && !last_byte) begin
            shift_reg <= shift_reg >> DATA_BITS;
            byte_idx  <= byte_idx + IDX_W'(1);
        end
    end

    assign o_uart_tx_start = (state == S_START);
    assign o_uart_tx_data  = shift_reg[DATA_BITS-1:0];
    assign o_busy          = (state != S_IDLE) || (count != '0);
    assign o_fifo_count    = count;
    assign o_overflow      = overflow;
    assign o_dbg_state     = state;

endmodule

// File: tb/tb_debug_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_debug_word_serializer
//
// This bench checks debug_word_serializer against a byte scoreboard. Each
// accepted word pushes its expected bytes, LSB first, into exp_q. A monitor
// pops one expected byte for every start pulse the DUT issues. A small
// transmitter model answers each start with a done pulse, after a fixed or
// random delay, or not at all while it is held off. It can also inject done
// pulses on request.
// -----------------------------------------------------------------------------
module tb_debug_word_serializer;

    localparam int NB     = 32;
    localparam int DB     = 8;
    localparam int DEPTH  = 4;
    localparam int NBYTES = NB / DB;
    localparam int CW     = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           word_valid = 1'b0;
    logic [NB-1:0]  word_data = '0;
    logic           tx_done = 1'b0;
    logic           word_ready;
    logic           tx_start;
    logic [DB-1:0]  tx_data;
    logic           busy;
    logic [CW-1:0]  fifo_count;
    logic           overflow;
    logic [1:0]     dbg_state;

    always #5 clk = ~clk;

    debug_word_serializer #(
        .NB(NB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .i_word_valid    (word_valid),
        .i_word_data     (word_data),
        .o_word_ready    (word_ready),
        .i_uart_tx_done  (tx_done),
        .o_uart_tx_start (tx_start),
        .o_uart_tx_data  (tx_data),
        .o_busy          (busy),
        .o_fifo_count    (fifo_count),
        .o_overflow      (overflow),
        .o_dbg_state     (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DB-1:0] exp_q[$];
    int            total_starts = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: checks the bytes, the pulse width and that the data stays stable in WAIT
    initial begin : monitor
        bit            prev_start;
        bit            waiting;
        logic [DB-1:0] wait_data;
        logic [DB-1:0] exp_byte;
        prev_start = 0;
        waiting    = 0;
        wait_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_start = 0;
                waiting    = 0;
            end else begin
                if (tx_start) begin
                    total_starts++;
                    check_eq("start_pulse_width", prev_start, 0);
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_start", 1, 0);
                    end else begin
                        exp_byte = exp_q.pop_front();
                        check_eq("tx_byte", tx_data, exp_byte);
                    end
                    wait_data = tx_data;
                    waiting   = 1;
                end else if (waiting) begin
                    check_eq("wait_data_stable", tx_data, wait_data);
                    if (tx_done) waiting = 0;
                end
                prev_start = tx_start;
            end
        end
    end

    // Transmitter model. It runs 2 ns after each edge, so requests the main
    // process makes at +1 ns apply in that same cycle.
    bit tx_en         = 1;
    bit tx_rand       = 0;
    bit spur_req      = 0;
    bit spur_in_start = 0;
    int tx_delay      = 10;

    initial begin : tx_model
        bit pending;
        int cnt;
        pending = 0;
        cnt     = 0;
        forever begin
            @(posedge clk);
            #2;
            tx_done = 1'b0;
            if (!rst_n) begin
                pending = 0;
            end else if (spur_req) begin
                tx_done  = 1'b1;
                spur_req = 0;
                pending  = 0;
            end else if (tx_start) begin
                pending = 1;
                cnt     = tx_rand ? int'($urandom_range(1, 6)) : tx_delay;
                if (spur_in_start) tx_done = 1'b1;
            end else if (pending && tx_en) begin
                if (cnt <= 1) begin
                    tx_done = 1'b1;
                    pending = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // ---------------- driver tasks (called at posedge + 1 ns) ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        word_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic push_once(input logic [NB-1:0] w, output bit acc);
        word_valid = 1'b1;
        word_data  = w;
        acc        = word_ready;
        @(posedge clk);
        #1 word_valid = 1'b0;
        if (acc) begin
            for (int b = 0; b < NBYTES; b++) exp_q.push_back(w[b*DB +: DB]);
        end
    endtask

    task automatic send_word(input logic [NB-1:0] w);
        bit acc;
        int tries;
        tries = 0;
        do begin
            push_once(w, acc);
            tries++;
        end while (!acc && tries < 200);
        check_eq("send_accepted", acc, 1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while ((busy || exp_q.size() != 0) && i < budget) begin
            step(1);
            i++;
        end
        check_eq("drain_done", (busy || exp_q.size() != 0), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin : main
        int base;
        int acc_n;
        int i;
        bit acc;
        int exp_cnt_seq[5];
        exp_cnt_seq = '{1, 2, 2, 3, 4};

        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        check_eq("rst_ready", word_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_start", tx_start, 0);
        check_eq("rst_data", tx_data, 0);
        check_eq("rst_overflow", overflow, 0);

        // One word with a fixed done delay of 10 cycles
        tx_en = 1; tx_delay = 10;
        base = total_starts;
        push_once(32'hDEADBEEF, acc);
        check_eq("t1_accept", acc, 1);
        check_eq("t1_count", fifo_count, 1);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_start_k", tx_start, 0);
        step(1);
        check_eq("t1_start_k1", tx_start, 0);
        step(1);
        check_eq("t1_start_k2", tx_start, 1);
        wait_drain(300);
        check_eq("t1_start_count", total_starts - base, 4);
        check_eq("t1_busy_after", busy, 0);

        // Done held low: fill the FIFO, then overflow
        tx_en = 0;
        base  = total_starts;
        acc_n = 0;
        for (int w = 0; w < 5; w++) begin
            push_once(NB'(w + 1), acc);
            acc_n += int'(acc);
            check_eq("t2_count_seq", fifo_count, exp_cnt_seq[w]);
        end
        check_eq("t2_accepted", acc_n, 5);
        check_eq("t2_ready_full", word_ready, 0);
        check_eq("t2_count_full", fifo_count, 4);
        check_eq("t2_no_overflow_yet", overflow, 0);
        push_once(32'h6, acc);
        check_eq("t2_sixth_rejected", acc, 0);
        check_eq("t2_overflow", overflow, 1);
        check_eq("t2_count_kept", fifo_count, 4);

        // Finish word 1 with injected dones, so word 2 is popped
        for (int d = 0; d < NBYTES; d++) begin
            spur_req = 1;
            step(3);
        end
        step(1);
        check_eq("t3_count_before", fifo_count, 3);
        // A done pulse and a push on the same edge
        spur_req = 1;
        push_once(32'h7, acc);
        check_eq("t3_push_accepted", acc, 1);
        check_eq("t3_count_after", fifo_count, 4);
        check_eq("t3_done_honoured", tx_start, 1);
        // Drain with spurious done pulses during every START cycle
        spur_in_start = 1;
        tx_delay = 3;
        tx_en = 1;
        wait_drain(2000);
        spur_in_start = 0;
        check_eq("t3_start_count", total_starts - base, 24);
        check_eq("t3_overflow_sticky", overflow, 1);

        // Spurious done pulse while IDLE
        base = total_starts;
        spur_req = 1;
        step(10);
        check_eq("idle_spur_starts", total_starts - base, 0);
        check_eq("idle_spur_busy", busy, 0);
        check_eq("idle_spur_count", fifo_count, 0);

        // Reset in the middle of a word, with 3 words queued
        tx_delay = 10;
        base = total_starts;
        for (int w = 0; w < 4; w++) send_word($urandom());
        i = 0;
        while (total_starts < base + 2 && i < 500) begin
            step(1);
            i++;
        end
        check_eq("t4_two_bytes_out", (total_starts >= base + 2), 1);
        step(5);
        check_eq("t4_count_before_rst", fifo_count, 3);
        check_eq("t4_overflow_before_rst", overflow, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        check_eq("t4_rst_count", fifo_count, 0);
        check_eq("t4_rst_busy", busy, 0);
        check_eq("t4_rst_overflow", overflow, 0);
        check_eq("t4_rst_start", tx_start, 0);
        check_eq("t4_rst_ready", word_ready, 1);
        base = total_starts;
        step(30);
        check_eq("t4_no_starts_after_rst", total_starts - base, 0);
        send_word(32'h0000_0080);
        wait_drain(300);
        check_eq("t4_new_word_starts", total_starts - base, 4);

        // Random valid gaps and random done delays
        tx_rand = 1;
        base = total_starts;
        for (int w = 0; w < 200; w++) begin
            step($urandom_range(0, 2));
            send_word($urandom());
        end
        wait_drain(20000);
        check_eq("t5_start_count", total_starts - base, 800);
        check_eq("t5_busy_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
